// File: rtl/uart_pkg.sv
// Shared types and codes for the uart_rx receiver: FSM states, stop/parity codes and the
// received-word payload carried through the output stage.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP1,
        STOP2,
        DONE
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam logic [1:0] STOP_0 = 2'd0;
    localparam logic [1:0] STOP_1 = 2'd1;
    localparam logic [1:0] STOP_2 = 2'd2;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_word_t;

    localparam int DIV_MIN = 4;

    // State entered once the payload (data and optional parity) has been sampled.
    function automatic rx_state_e tail_state(input logic [1:0] stop_code);
        return (stop_code != STOP_0) ? STOP1 : DONE;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready output bus of the UART receiver: received byte plus its per-word error flags.
interface uart_rx_if;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       valid;
    logic       ready;

    modport master (output data, perr, ferr, valid, input ready);
    modport slave  (input data, perr, ferr, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Power-of-two receive FIFO of rx_word_t entries; a push and a pop in the same cycle are
// both honoured even when full, since the popped head slot becomes the new tail.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push_i,
    input  rx_word_t wdata_i,
    input  logic     pop_i,
    output rx_word_t rdata_o,
    output logic     empty_o,
    output logic     full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rx_word_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic            do_pop, do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit async serial receiver, 2-flop input sync, mid-bit sampling, valid/ready output.
// Define UART_RX_FIFO_EN to replace the single holding register by a FIFO_DEPTH-entry FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       stop,
    input  logic [1:0]       parity,
    input  logic             rx,
    uart_rx_if.master        bus,
    output logic             overrun,
    output logic             busy
);
    rx_state_e        state_q, state_d;
    logic [1:0]       sync_q;
    logic             rxs_prev_q;
    logic             rxs;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_eff, div_m1;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             perr_q, perr_d, ferr_q, ferr_d;
    logic [1:0]       stop_n, par_n;
    logic             par_en;
    logic             tick, push, pop;
    logic             ovr_q;
    rx_word_t         word_in, out_w;
    logic             out_vld;

    assign rxs     = sync_q[1];
    assign div_eff = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;
    assign div_m1  = div_eff - DIV_W'(1);
    assign stop_n  = (stop == 2'd3) ? STOP_1 : stop;
    assign par_n   = (parity == 2'd3) ? PAR_NONE : parity;
    assign par_en  = (par_n == PAR_ODD) || (par_n == PAR_EVEN);
    assign tick    = (cnt_q == '0);
    assign busy    = (state_q != IDLE);
    assign word_in = {ferr_q, perr_q, shift_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
        end else begin
            sync_q     <= {sync_q[0], rx};
            rxs_prev_q <= rxs;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
        end
    end

    // Frame payload registers carry no reset: they are always reinitialised at a start edge.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        perr_q  <= perr_d;
        ferr_q  <= ferr_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;

        if (state_q != IDLE && state_q != DONE && !tick) cnt_d = cnt_q - DIV_W'(1);

        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    cnt_d   = div_eff >> 1;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d   = div_m1;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = div_m1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = par_en ? PAR : tail_state(stop_n);
                end
            end
            PAR: begin
                if (tick) begin
                    perr_d  = (par_n == PAR_ODD) ? ~^{shift_q, rxs} : ^{shift_q, rxs};
                    cnt_d   = div_m1;
                    state_d = tail_state(stop_n);
                end
            end
            STOP1: begin
                if (tick) begin
                    ferr_d  = ferr_q | ~rxs;
                    cnt_d   = div_m1;
                    state_d = (stop_n == STOP_2) ? STOP2 : DONE;
                end
            end
            STOP2: begin
                if (tick) begin
                    ferr_d  = ferr_q | ~rxs;
                    state_d = DONE;
                end
            end
            DONE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!en) state_d = IDLE;
    end

`ifdef UART_RX_FIFO_EN
    logic empty, full;

    assign pop     = !empty && bus.ready;
    assign out_vld = !empty;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .wdata_i (word_in),
        .pop_i   (pop),
        .rdata_o (out_w),
        .empty_o (empty),
        .full_o  (full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovr_q <= 1'b0;
        else       ovr_q <= push && full && !pop;
    end
`else
    rx_word_t hold_q;
    logic     valid_q;

    assign pop     = valid_q && bus.ready;
    assign out_w   = hold_q;
    assign out_vld = valid_q;

    // A word arriving while the held one is not being taken is dropped, old word kept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= push && valid_q && !bus.ready;
            if (push && (!valid_q || bus.ready)) begin
                hold_q  <= word_in;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end
`endif

    assign bus.data  = out_w.data;
    assign bus.perr  = out_w.perr;
    assign bus.ferr  = out_w.ferr;
    assign bus.valid = out_vld;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial transmitter model drives rx, expected words are
// queued from a frame-level reference model and a monitor compares each accepted word.
module tb_uart_rx;
    import uart_pkg::*;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH_M = 4;
`else
    localparam int DEPTH_M = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn, en, rx;
    logic [15:0] div;
    logic [1:0]  stop, parity;
    logic        overrun, busy;

    uart_rx_if bus ();

    uart_rx #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .div     (div),
        .stop    (stop),
        .parity  (parity),
        .rx      (rx),
        .bus     (bus),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    logic [9:0] exp_q[$];
    int         ovr_cnt = 0, vld_cyc = 0, busy_cyc = 0, words = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every word the consumer accepts is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rstn) begin
            if (overrun) ovr_cnt++;
            if (busy) busy_cyc++;
            if (bus.valid) vld_cyc++;
            if (bus.valid && bus.ready) begin
                words++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h expected none",
                             {bus.ferr, bus.perr, bus.data});
                end else begin
                    check("word", int'({bus.ferr, bus.perr, bus.data}), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: frame settings and injected faults -> {ferr, perr, data}.
    function automatic logic [9:0] model_word(input logic [7:0] b, input int s, input int p,
                                              input bit bad_par, input int bad_stop);
        int ns = (s == 3) ? 1 : s;
        bit pe = (p == 1) || (p == 2);
        return {(bad_stop > 0) && (bad_stop <= ns), bad_par && pe, b};
    endfunction

    // Serial transmitter; bad_stop = k drives stop bit k low.
    task automatic send(input logic [7:0] b, input int d, input int s, input int p,
                        input bit bad_par, input int bad_stop);
        int de = (d < 4) ? 4 : d;
        int ns = (s == 3) ? 1 : s;
        logic pb;
        rx = 1'b0;
        cyc(de);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(de);
        end
        if (p == 1 || p == 2) begin
            pb = (p == 1) ? ~^b : ^b;
            rx = pb ^ bad_par;
            cyc(de);
        end
        for (int k = 1; k <= ns; k++) begin
            rx = (bad_stop != k);
            cyc(de);
        end
        rx = 1'b1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            cyc(1);
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic frame(input logic [7:0] b, input int d, input int s, input int p,
                         input bit bad_par, input int bad_stop);
        div    = 16'(d);
        stop   = 2'(s);
        parity = 2'(p);
        cyc(2);
        exp_q.push_back(model_word(b, s, p, bad_par, bad_stop));
        send(b, d, s, p, bad_par, bad_stop);
        cyc(2 * ((d < 4) ? 4 : d));
        drain();
    endtask

    initial begin
        int w0;
        rstn = 1'b0; en = 1'b1; rx = 1'b1; bus.ready = 1'b1;
        div = 16'd25; stop = 2'd1; parity = 2'd0;
        cyc(3);
        check("rst_data", bus.data, 0);
        check("rst_perr", bus.perr, 0);
        check("rst_ferr", bus.ferr, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rstn = 1'b1;
        cyc(5);

        vld_cyc = 0;
        frame(8'hA5, 25, 1, 0, 0, 0);
        check("a5_valid_cycles", vld_cyc, 1);
        check("a5_busy_fell", busy, 0);

        frame(8'h3C, 25, 2, 2, 0, 0);
        frame(8'h3C, 25, 2, 2, 1, 0);
        frame(8'h55, 25, 1, 0, 0, 1);

        // Short low glitch: false start, no word.
        busy_cyc = 0; w0 = words;
        rx = 1'b0; cyc(5); rx = 1'b1;
        cyc(60);
        check("glitch_busy_in_12_14", int'(busy_cyc >= 12 && busy_cyc <= 14), 1);
        check("glitch_no_word", words - w0, 0);

        // Consumer stalled: DEPTH_M words held, the next one overruns.
        bus.ready = 1'b0; ovr_cnt = 0; div = 16'd25; stop = 2'd1; parity = 2'd0;
        for (int i = 0; i <= DEPTH_M; i++) begin
            logic [7:0] b;
            b = 8'(8'h11 * (i + 1));
            if (i == DEPTH_M) check("no_overrun_before_full", ovr_cnt, 0);
            if (i < DEPTH_M) exp_q.push_back(model_word(b, 1, 0, 0, 0));
            send(b, 25, 1, 0, 0, 0);
            cyc(50);
        end
        check("stall_valid", bus.valid, 1);
        check("stall_head_data", bus.data, 8'h11);
        check("overrun_pulses", ovr_cnt, 1);
        bus.ready = 1'b1;
        drain();

        // Receiver disabled during data bit 4.
        w0 = words;
        fork
            send(8'hC3, 25, 1, 0, 0, 0);
            begin
                cyc(25 * 5 + 12);
                en = 1'b0;
                cyc(2);
                check("en_low_busy", busy, 0);
            end
        join
        en = 1'b1;
        cyc(50);
        check("en_abort_no_word", words - w0, 0);
        frame(8'h0F, 25, 1, 0, 0, 0);

        // Reset during data bit 4.
        w0 = words;
        fork
            send(8'hC3, 25, 1, 0, 0, 0);
            begin
                cyc(25 * 5 + 12);
                rstn = 1'b0;
                cyc(2);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_valid", bus.valid, 0);
                check("rst_mid_data", bus.data, 0);
            end
        join
        rstn = 1'b1;
        cyc(50);
        check("rst_abort_no_word", words - w0, 0);
        frame(8'h0F, 25, 1, 0, 0, 0);

        // Randomised frames across divisor, stop, parity and fault settings.
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            int d, s, p, bs;
            bit bp;
            b  = 8'($urandom);
            d  = $urandom_range(2, 30);
            s  = $urandom_range(0, 3);
            p  = $urandom_range(0, 3);
            bp = 1'($urandom_range(0, 1));
            bs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            frame(b, d, s, p, bp, bs);
        end

        cyc(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the SoC serial pad path.
- Receiving end of the same 8-bit async serial protocol the tty transmitter model drives onto PAD_4.
- Accepts the same runtime stop/parity codes as that transmitter and oversamples with the core clock using a programmable per-bit divisor.
- Delivers each received byte plus its error flags over a valid/ready interface to the CPU/peripheral bus side.

Parameters:
- DIV_W, 16: width of the divisor input.
- FIFO_DEPTH, 4: receive FIFO entries, power of two. Used only when UART_RX_FIFO_EN is defined.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  receiver enable; low aborts any frame and holds the FSM in IDLE.
- div  in  DIV_W  clk cycles per bit; values below 4 are treated as 4.
- stop  in  2  stop bits: 0 = none, 1 = one, 2 = two, 3 = treated as 1.
- parity  in  2  0 = none, 1 = odd, 2 = even, 3 = treated as none.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data  out  8  received byte.
- perr  out  1  parity error flag, qualified by valid.
- ferr  out  1  framing error (a stop bit sampled low), qualified by valid.
- valid  out  1  output word available.
- ready  in  1  consumer accepts the word on clk when valid && ready.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset values: data = 0, perr = 0, ferr = 0, valid = 0, overrun = 0, busy = 0.
- Reset state: synchronizer = 2'b11, FSM = IDLE, bit counter = 0.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- The divisor counter cnt counts down. A "tick" occurs when cnt == 0.
- IDLE: on a falling edge of rxs (previous 1, now 0), load cnt = div>>1 and go to START.
- START: on tick, if rxs == 0 load cnt = div-1 and go to DATA; otherwise (false start) return to IDLE with no output.
- DATA: on each tick, shift rxs into bit n, LSB first, and reload cnt = div-1. After bit 7 go to PAR if parity is 1 or 2, else STOP1 if stop != 0, else DONE.
- PAR: on tick, compute perr:
  - odd: perr = ~^{data, pbit}
  - even: perr = ^{data, pbit}
  - Then go to STOP1 or DONE as above.
- STOP1: on tick, ferr |= ~rxs. Go to STOP2 if stop == 2, else DONE.
- STOP2: on tick, ferr |= ~rxs, then go to DONE.
- DONE: one cycle; push the word {ferr, perr, data} to the output stage and go to IDLE.
  - A new start edge is recognised from the next cycle.
  - With stop == 0, the mid-point of the last data/parity bit acts as the frame end.
- Output stage without FIFO: a single holding register.
  - Push when !valid, or when valid && ready in the same cycle: the register loads, valid = 1, overrun = 0.
  - Push when valid && !ready: the new word is discarded, the old word is kept, and overrun pulses for 1 cycle.
- Latency: valid rises on the clk edge after DONE, i.e. 1 cycle after the final sample tick.
- Error flags belong to their word; they are not sticky across words.
- en low: the FSM goes to IDLE on the next edge and the partial frame is discarded without error. The output stage and valid are untouched.
- rstn asserted mid-frame: immediate return to reset values, and the pending word is lost.
- Changing div, stop or parity mid-frame is undefined. Software changes them only while busy == 0.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined: the output stage is a FIFO_DEPTH-entry FIFO of 10-bit words.
  - valid = !empty; data, perr and ferr show the head entry.
  - A push and a pop in the same cycle are both honoured, even when full.
  - overrun pulses only when pushing to a full FIFO with no simultaneous pop; the incoming word is dropped.
- Undefined: single holding register as described above (depth 1).

Decomposition:
- Package uart_pkg contains:
  - state enum: IDLE, START, DATA, PAR, STOP1, STOP2, DONE
  - parity codes: PAR_NONE, PAR_ODD, PAR_EVEN
  - stop codes: STOP_0, STOP_1, STOP_2
  - packed struct rx_word_t {ferr, perr, data[7:0]}
  - constant DIV_MIN = 4
- Sub-module uart_rx_fifo (parameterised depth, rx_word_t payload) is instantiated only under UART_RX_FIFO_EN.

Test Plan:
- div = 25, stop = 1, parity = 0; send 0xA5 from the tty transmitter model, ready = 1 -> data = 0xA5, perr = 0, ferr = 0, valid high for 1 cycle, busy falls.
- div = 25, parity = 2 (even), stop = 2; send 0x3C with a correct parity bit, then 0x3C with the parity bit inverted -> word 1 perr = 0, word 2 perr = 1, both ferr = 0.
- Force the stop bit low on byte 0x55 with stop = 1 -> data = 0x55, ferr = 1.
- Drive a 0 glitch of 5 cycles with div = 25 -> no valid, FSM returns to IDLE, busy high for 12–14 cycles only.
- ready = 0, send 0x11 then 0x22 -> non-FIFO build: data stays 0x11, overrun pulses once. FIFO build (depth 4): both words are queued, and the 5th un-popped byte causes overrun.
- Deassert rstn and, separately, en during data bit 4 of a frame -> no valid. The next full frame 0x0F is received correctly.
